// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: reset/bus conventions,
// stall vector bit positions, stall patterns and FSM state encodings.
package pipe_ctrl_pkg;

  localparam logic        RST_ENABLE = 1'b1;
  localparam int          REG_BUS_W  = 32;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  // Bit positions inside the stall vector; 1 means "hold this stage".
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  // A requesting stage freezes itself and every stage upstream of it.
  localparam logic [5:0] STALL_NONE     = 6'b000000;
  localparam logic [5:0] STALL_FROM_ID  = 6'b000111;
  localparam logic [5:0] STALL_FROM_EX  = 6'b001111;
  localparam logic [5:0] STALL_FROM_MEM = 6'b011111;

  // Controller states, kept as plain constants for older tooling.
  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_STALLED = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;

  // Picks the stall pattern of the furthest-downstream requester.
  function automatic logic [5:0] stall_select(input logic req_id,
                                              input logic req_ex,
                                              input logic req_mem);
    logic [5:0] s;
    s = STALL_NONE;
    if (req_mem)     s = STALL_FROM_MEM;
    else if (req_ex) s = STALL_FROM_EX;
    else if (req_id) s = STALL_FROM_ID;
    return s;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones, and
// returns to zero on reset or clear.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear wins, otherwise add one unless already saturated.
  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (inc && (count_q != {WIDTH{1'b1}}))
      count_d = count_q + WIDTH'(1);
  end

  // Counter register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller for the 5-stage core: builds the stall vector from
// per-stage requests, sequences a one-cycle flush with a redirect PC,
// counts stalled cycles and flags a stall run that never ends.
// Handshake: flush_req is a single-cycle strobe sampled with flush_pc on
// the clock edge; the resulting flush/new_pc are valid in the next cycle
// only, with no ready/back-pressure path.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STALL_TIMEOUT = 1024,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stallreq_id,
  input  logic                 stallreq_ex,
  input  logic                 stallreq_mem,
  input  logic                 flush_req,
  input  logic [REG_BUS_W-1:0] flush_pc,
  output logic [5:0]           stall,
  output logic                 flush,
  output logic [REG_BUS_W-1:0] new_pc,
  output logic [31:0]          stall_cycles,
  output logic                 stall_timeout,
  output logic [1:0]           dbg_state
);

  logic [1:0]           state_q,   state_d;
  logic                 flush_q,   flush_d;
  logic [REG_BUS_W-1:0] new_pc_q,  new_pc_d;
  logic [CNT_W-1:0]     run_cnt_q, run_cnt_d;
  logic                 timeout_q, timeout_d;
  logic                 stall_active;

  // Stall vector: nothing is held in reset, while a flush is requested or
  // while the pipeline is being cleared; otherwise deepest requester wins.
  always_comb begin
    stall = STALL_NONE;
    if (!(rst == RST_ENABLE || state_q == ST_FLUSH || flush_req))
      stall = stall_select(stallreq_id, stallreq_ex, stallreq_mem);
  end

  assign stall_active = |stall;

  // Next state, redirect latch, run counter and sticky watchdog.
  always_comb begin
    state_d   = state_q;
    new_pc_d  = new_pc_q;
    flush_d   = flush_req;
    timeout_d = timeout_q;
    run_cnt_d = '0;
    if (flush_req) begin
      state_d  = ST_FLUSH;
      new_pc_d = flush_pc;
    end else if (stall_active) begin
      state_d = ST_STALLED;
    end else begin
      state_d = ST_RUN;
    end
    // A flush forces stall to zero, so the run counter clears on entry.
    if (stall_active) begin
      if (run_cnt_q != {CNT_W{1'b1}}) run_cnt_d = run_cnt_q + CNT_W'(1);
      else                            run_cnt_d = run_cnt_q;
      if (run_cnt_q == CNT_W'(STALL_TIMEOUT - 1)) timeout_d = 1'b1;
    end
  end

  // Controller registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q   <= ST_RUN;
      flush_q   <= 1'b0;
      new_pc_q  <= ZERO_WORD;
      run_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flush_q   <= flush_d;
      new_pc_q  <= new_pc_d;
      run_cnt_q <= run_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  sat_counter #(.WIDTH(32)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .inc   (stall_active),
    .count (stall_cycles)
  );

  assign flush         = flush_q;
  assign new_pc        = new_pc_q;
  assign stall_timeout = timeout_q;
  assign dbg_state     = state_q;

endmodule
